// File: rtl/seg7_digit_reader.sv
// +--------------------------------------------------------------------------+
// | seg7_digit_reader                                                        |
// | Debounces an asynchronous 7-segment bus, decodes it to BCD and checks    |
// | that digits follow the 0..9..0 increment sequence.                       |
// | Option macro: SEG7_READER_ERRCNT_EN (implements error_count, else 0).    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module seg7_digit_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    output logic [3:0] digit_out,
    output logic       digit_valid,
    output logic       new_digit,
    output logic       seq_error,
    output logic       bad_pattern,
    output logic [7:0] error_count
);

    localparam logic [3:0] C_STABLE     = 4'(STABLE_CYCLES);
    localparam logic [3:0] C_ACCEPT_CNT = 4'(STABLE_CYCLES - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;

    logic [6:0] s1_q, s2_q, cand_q, last_pat_q;
    logic [3:0] cnt_q;
    logic [0:0] state_q, state_d;
    logic [3:0] digit_q, digit_d;
    logic       valid_q, valid_d;
    logic       new_q, new_d;
    logic       seqerr_q, seqerr_d;
    logic       badpat_q, badpat_d;

    logic       w_accept, w_event, w_dec_valid;
    logic [3:0] w_dec_digit, w_exp_next;

    // Synchronizer and debounce; cnt saturates so each stable run yields one acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q   <= 7'h00;
            s2_q   <= 7'h00;
            cand_q <= 7'h00;
            cnt_q  <= 4'd0;
        end else begin
            s1_q <= seg_in;
            s2_q <= s1_q;
            if (s2_q != cand_q) begin
                cand_q <= s2_q;
                cnt_q  <= 4'd1;
            end else if (cnt_q < C_STABLE) begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    assign w_accept = (s2_q == cand_q) && (cnt_q == C_ACCEPT_CNT);
    assign w_event  = w_accept && (cand_q != last_pat_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_pat_q <= 7'h00;
        end else if (w_event) begin
            last_pat_q <= cand_q;
        end
    end

    always_comb begin
        w_dec_valid = 1'b1;
        w_dec_digit = 4'd0;
        case (cand_q)
            7'h3F: w_dec_digit = 4'd0;
            7'h06: w_dec_digit = 4'd1;
            7'h5B: w_dec_digit = 4'd2;
            7'h4F: w_dec_digit = 4'd3;
            7'h66: w_dec_digit = 4'd4;
            7'h6D: w_dec_digit = 4'd5;
            7'h7D: w_dec_digit = 4'd6;
            7'h07: w_dec_digit = 4'd7;
            7'h7F: w_dec_digit = 4'd8;
            7'h6F: w_dec_digit = 4'd9;
            default: w_dec_valid = 1'b0;
        endcase
    end

    assign w_exp_next = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            digit_q  <= 4'd0;
            valid_q  <= 1'b0;
            new_q    <= 1'b0;
            seqerr_q <= 1'b0;
            badpat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            digit_q  <= digit_d;
            valid_q  <= valid_d;
            new_q    <= new_d;
            seqerr_q <= seqerr_d;
            badpat_q <= badpat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (w_event) begin
            case (state_q)
                ST_IDLE:  if (w_dec_valid)  state_d = ST_TRACK;
                ST_TRACK: if (!w_dec_valid) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        digit_d  = digit_q;
        valid_d  = valid_q;
        new_d    = 1'b0;
        seqerr_d = 1'b0;
        badpat_d = 1'b0;
        if (w_event) begin
            if (w_dec_valid) begin
                digit_d = w_dec_digit;
                valid_d = 1'b1;
                new_d   = 1'b1;
                if ((state_q == ST_TRACK) && (w_dec_digit != w_exp_next)) begin
                    seqerr_d = 1'b1;
                end
            end else begin
                // digit_out keeps the last good value for the host to inspect
                badpat_d = 1'b1;
                valid_d  = 1'b0;
            end
        end
    end

`ifdef SEG7_READER_ERRCNT_EN
    logic [7:0] errcnt_q;
    logic       w_err_event;

    assign w_err_event = seqerr_d | badpat_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            errcnt_q <= 8'd0;
        end else if (w_err_event && (errcnt_q != 8'hFF)) begin
            errcnt_q <= errcnt_q + 8'd1;
        end
    end

    assign error_count = errcnt_q;
`else
    assign error_count = 8'd0;
`endif

    assign digit_out   = digit_q;
    assign digit_valid = valid_q;
    assign new_digit   = new_q;
    assign seq_error   = seqerr_q;
    assign bad_pattern = badpat_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_digit_reader.sv
// +--------------------------------------------------------------------------+
// | tb_seg7_digit_reader                                                     |
// | Self-checking bench: vector table + event scoreboard for the reader.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_seg7_digit_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_in = 7'h00;
    logic [3:0] digit_out;
    logic       digit_valid, new_digit, seq_error, bad_pattern;
    logic [7:0] error_count;

    always #5 clk = ~clk;

    seg7_digit_reader #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .digit_out   (digit_out),
        .digit_valid (digit_valid),
        .new_digit   (new_digit),
        .seq_error   (seq_error),
        .bad_pattern (bad_pattern),
        .error_count (error_count)
    );

    typedef struct packed {
        logic       nd;
        logic       se;
        logic       bp;
        logic [3:0] dig;
        logic       val;
        logic [7:0] err;
    } ev_t;

    typedef struct {
        logic [6:0] pat;
        int         hold;
        logic       ev;
        ev_t        exp;
    } vec_t;

    ev_t  sb_q[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [7:0] errv(int x);
`ifdef SEG7_READER_ERRCNT_EN
        return (x > 255) ? 8'd255 : 8'(x);
`else
        return 8'd0 + 8'(x * 0);
`endif
    endfunction

    function automatic vec_t mk(logic [6:0] pat, int hold, logic ev, logic nd, logic se,
                                logic bp, logic [3:0] dig, logic val, int err);
        vec_t v;
        v.pat  = pat;
        v.hold = hold;
        v.ev   = ev;
        v.exp  = '{nd: nd, se: se, bp: bp, dig: dig, val: val, err: errv(err)};
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: every output event is matched against the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && (new_digit || seq_error || bad_pattern)) begin
            ev_t act, e;
            act = '{nd: new_digit, se: seq_error, bp: bad_pattern, dig: digit_out,
                    val: digit_valid, err: error_count};
            if (sb_q.size() == 0) begin
                check("unexpected_event", 32'(act), 32'h0);
            end else begin
                e = sb_q.pop_front();
                check("event", 32'(act), 32'(e));
            end
        end
    end

    task automatic apply(vec_t v, string name);
        seg_in = v.pat;
        if (v.ev) sb_q.push_back(v.exp);
        repeat (v.hold) @(posedge clk);
        #1;
        check({name, "_digit"}, 32'(digit_out), 32'(v.exp.dig));
        check({name, "_valid"}, 32'(digit_valid), 32'(v.exp.val));
        check({name, "_errcnt"}, 32'(error_count), 32'(v.exp.err));
    endtask

    initial begin
        int   errs;
        logic [3:0] dig;
        logic [6:0] pat;
        logic [6:0] codes [10];
        codes = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {digit_out, digit_valid, new_digit, seq_error, bad_pattern, error_count},
              32'h0);
        rst_n = 1'b1;

        // Blank after reset is not an error
        repeat (20) @(posedge clk);
        #1;
        check("blank_no_event", {new_digit, seq_error, bad_pattern, digit_valid, error_count}, 32'h0);

        // Latency: pulse at edge 5 after the change, not before
        seg_in = 7'h3F;
        sb_q.push_back('{nd: 1'b1, se: 1'b0, bp: 1'b0, dig: 4'd0, val: 1'b1, err: errv(0)});
        for (int e = 0; e <= 5; e++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("latency_edge%0d", e), 32'(new_digit), (e == 5) ? 32'd1 : 32'd0);
        end
        repeat (4) @(posedge clk);
        #1;

        // Vector table: full count sequence, sequence error, glitch, bad patterns
        for (int d = 1; d <= 10; d++) vecs.push_back(mk(codes[d % 10], 10, 1, 1, 0, 0, 4'(d % 10), 1, 0));
        vecs.push_back(mk(7'h06, 10, 1, 1, 0, 0, 4'd1, 1, 0));
        vecs.push_back(mk(7'h5B, 10, 1, 1, 0, 0, 4'd2, 1, 0));
        vecs.push_back(mk(7'h66, 10, 1, 1, 1, 0, 4'd4, 1, 1));
        vecs.push_back(mk(7'h6D, 10, 1, 1, 0, 0, 4'd5, 1, 1));
        vecs.push_back(mk(7'h7F,  3, 0, 0, 0, 0, 4'd5, 1, 1));
        vecs.push_back(mk(7'h6D, 10, 0, 0, 0, 0, 4'd5, 1, 1));
        vecs.push_back(mk(7'h49, 10, 1, 0, 0, 1, 4'd5, 0, 2));
        vecs.push_back(mk(7'h07, 10, 1, 1, 0, 0, 4'd7, 1, 2));
        vecs.push_back(mk(7'h00, 10, 1, 0, 0, 1, 4'd7, 0, 3));
        vecs.push_back(mk(7'h49, 10, 1, 0, 0, 1, 4'd7, 0, 4));
        vecs.push_back(mk(7'h7F, 10, 1, 1, 0, 0, 4'd8, 1, 4));
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Mid-run reset clears everything
        seg_in = 7'h00;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        check("midrun_rst", {digit_out, digit_valid, new_digit, seq_error, bad_pattern, error_count},
              32'h0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // Saturation: alternating 0 / 2, every transition after the first is an error
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            pat = (i % 2 == 0) ? 7'h3F : 7'h5B;
            dig = (i % 2 == 0) ? 4'd0 : 4'd2;
            if (i > 0) errs++;
            seg_in = pat;
            sb_q.push_back('{nd: 1'b1, se: (i > 0), bp: 1'b0, dig: dig, val: 1'b1, err: errv(errs)});
            repeat (6) @(posedge clk);
        end
        repeat (4) @(posedge clk);
        #1;
        check("errcnt_saturated", 32'(error_count), 32'(errv(300)));
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
